ifu: RTL and testbench
======================

# ifu

Instruction fetch unit: the PC owner that consumes the `exu` outputs `jump_branch_o_exu`/`dnpc_o_exu` and produces the instruction/PC pair the decode/execute path works on. Holds the architectural PC, issues one fetch at a time to instruction memory over a valid/ready request and a valid response, and presents each instruction to decode until it is accepted. Applies branch/jump redirects at instruction retirement and asynchronous flushes, used for trap entry and return, in any state, squashing the in-flight fetch.

## Interface
- `RESET_PC`, 64'h8000_0000: PC loaded at reset.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid_o_ifu` out 1: fetch request valid.
- `req_addr_o_ifu` out 64: fetch address; always equals current PC.
- `req_ready_i_ifu` in 1: memory accepts request.
- `resp_valid_i_ifu` in 1: response valid, single cycle, one per accepted request.
- `resp_inst_i_ifu` in 32: instruction data.
- `inst_valid_o_ifu` out 1: instruction held for decode.
- `inst_o_ifu` out 32: held instruction.
- `pc_o_ifu` out 64: PC of held instruction.
- `inst_ready_i_ifu` in 1: decode/execute retires the held instruction this cycle.
- `jump_branch_i_ifu` in 1: taken jump/branch for the held instruction; from `exu`.
- `dnpc_i_ifu` in 64: redirect target; from `exu`.
- `flush_i_ifu` in 1: unconditional redirect, any state.
- `flush_pc_i_ifu` in 64: flush target.
- `misalign_o_ifu` out 1: misaligned-target fault. Exists only under `IFU_MISALIGN_TRAP_EN`.

## Operation
- States: REQ (drive request), WAIT (request accepted, response pending), HOLD (instruction presented), HALT (fault; macro builds only).
- REQ: `req_valid`=1. If `req_ready`, go to WAIT.
- WAIT: on `resp_valid`, latch `resp_inst` into `inst_o`, then go to HOLD.
- HOLD: `inst_valid`=1.
  - On `inst_ready`: next PC = `jump_branch` ? `dnpc_i` : PC+4, with 64-bit wrap. Then go to REQ.
  - `jump_branch` is ignored unless `inst_ready`=1.
- Flush has the highest priority.
  - PC is set to `flush_pc`, then go to REQ. A held instruction is dropped and `inst_valid` falls next cycle.
  - In WAIT, or in REQ with `req_ready`=1 in the same cycle, set `squash` and go to REQ. The request is held low until the stale response arrives, which is then discarded without latching. This guarantees one outstanding fetch.
  - A response arriving in the flush cycle itself counts as the stale response, so no squash is needed.
  - Flush in HOLD coincident with `inst_ready`: flush wins and the retirement redirect is ignored.
- Only one request is ever outstanding. `req_valid` is never asserted while `squash` is set or in WAIT/HOLD.
- `pc_o_ifu` and `req_addr_o_ifu` both come from the single PC register.

## Timing
- Reset (async assert) values:
  - State REQ, PC=`RESET_PC`, `squash`=0, `inst_o`=0.
  - `inst_valid`=0, `req_valid`=0, `misalign`=0.
  - `req_valid` rises on the first clock edge after `rst` deasserts.
- Request to presentation: `inst_valid` is asserted the cycle after `resp_valid`.
- Retire to next request: `req_valid` is asserted the cycle after the HOLD handshake, carrying the updated address.
- Zero-wait memory (ready=1, response the next cycle): one instruction every 3 cycles.
- Flush latency: `req_valid` with `flush_pc` one cycle after flush if nothing is in flight. If a fetch is in flight, one cycle after the stale response.
- Reset mid-fetch clears `squash`. A late response after reset arrives in REQ/WAIT and is treated as an ordinary response. Memory must be reset together with this block.

## Configuration
- `IFU_MISALIGN_TRAP_EN` defined: a redirect or flush target with bit[1:0]≠0 still loads PC, but the block enters HALT instead of REQ.
  - In HALT, `misalign_o_ifu`=1 (sticky) and no requests are issued.
  - Only `flush_i_ifu` with an aligned target leaves HALT. It clears `misalign` and goes to REQ.
- Undefined: target bits[1:0] are forced to 0 and there is no HALT state or `misalign` port.

## Test plan
- Reset release, ready=1, responses one cycle later → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008. `inst_valid` pulses with matching `pc_o`.
- HOLD with `inst_ready`=0 for 5 cycles → `inst_o`/`pc_o` stable, no request. Then `inst_ready`=1, `jump_branch`=1, `dnpc`=0x8000_0100 → next `req_addr`=0x8000_0100.
- Flush to 0x8000_0200 while in WAIT; the stale response arrives 3 cycles later with data 0xDEADBEEF → never presented. Next request is 0x8000_0200.
- Flush and `inst_ready`+`jump_branch` (dnpc 0x8000_0300) in the same HOLD cycle → next `req_addr`=0x8000_0200 (flush target).
- `req_ready`=0 for 4 cycles → `req_valid`, `req_addr` held constant. `rst` pulsed mid-WAIT → state REQ, PC=0x8000_0000 on deassert.
- Macro on: redirect to 0x8000_0102 → `misalign`=1, no requests. Flush to 0x8000_0000 → `misalign`=0, fetch resumes. Macro off: same redirect → `req_addr`=0x8000_0100.

Source files
------------

// File: rtl/ifu_if.sv
// Fetch-unit bus: instruction-memory request/response, decode handoff and redirect inputs.
// misalign_o_ifu is present only when IFU_MISALIGN_TRAP_EN is defined.
interface ifu_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  logic            req_valid_o_ifu;
  logic [XLEN-1:0] req_addr_o_ifu;
  logic            req_ready_i_ifu;
  logic            resp_valid_i_ifu;
  logic [ILEN-1:0] resp_inst_i_ifu;
  logic            inst_valid_o_ifu;
  logic [ILEN-1:0] inst_o_ifu;
  logic [XLEN-1:0] pc_o_ifu;
  logic            inst_ready_i_ifu;
  logic            jump_branch_i_ifu;
  logic [XLEN-1:0] dnpc_i_ifu;
  logic            flush_i_ifu;
  logic [XLEN-1:0] flush_pc_i_ifu;
`ifdef IFU_MISALIGN_TRAP_EN
  logic            misalign_o_ifu;
`endif

  // Fetch unit side
  modport master (
    output req_valid_o_ifu,
    output req_addr_o_ifu,
    input  req_ready_i_ifu,
    input  resp_valid_i_ifu,
    input  resp_inst_i_ifu,
    output inst_valid_o_ifu,
    output inst_o_ifu,
    output pc_o_ifu,
    input  inst_ready_i_ifu,
    input  jump_branch_i_ifu,
    input  dnpc_i_ifu,
    input  flush_i_ifu,
`ifdef IFU_MISALIGN_TRAP_EN
    output misalign_o_ifu,
`endif
    input  flush_pc_i_ifu
  );

  // Memory / decode / execute side
  modport slave (
    input  req_valid_o_ifu,
    input  req_addr_o_ifu,
    output req_ready_i_ifu,
    output resp_valid_i_ifu,
    output resp_inst_i_ifu,
    input  inst_valid_o_ifu,
    input  inst_o_ifu,
    input  pc_o_ifu,
    output inst_ready_i_ifu,
    output jump_branch_i_ifu,
    output dnpc_i_ifu,
    output flush_i_ifu,
`ifdef IFU_MISALIGN_TRAP_EN
    input  misalign_o_ifu,
`endif
    output flush_pc_i_ifu
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch in flight, presents instructions to decode.
// Define IFU_MISALIGN_TRAP_EN to halt on misaligned redirect/flush targets instead of masking bits[1:0].
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input logic    clk,
  input logic    rst,
  ifu_if.master  bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef IFU_MISALIGN_TRAP_EN
    , S_HALT = 2'd3
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic            squash_q, squash_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
`ifdef IFU_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  logic            req_fire;
  logic            in_flight;
  logic [XLEN-1:0] flush_tgt;
  logic [XLEN-1:0] redir_tgt;

  // Without the trap, redirect targets are silently word-aligned
  function automatic logic [XLEN-1:0] fix_tgt(input logic [XLEN-1:0] t);
`ifdef IFU_MISALIGN_TRAP_EN
    return t;
`else
    return t & ALIGN_MASK;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      squash_q     <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      squash_q     <= squash_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
`ifdef IFU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    squash_d  = squash_q;
    req_fire  = req_valid_q && bus.req_ready_i_ifu;
    // A fetch is outstanding if accepted now, awaiting response, or already squashed
    in_flight = (state_q == S_WAIT) || (state_q == S_REQ && req_fire) || squash_q;
    flush_tgt = fix_tgt(bus.flush_pc_i_ifu);
    redir_tgt = bus.jump_branch_i_ifu ? fix_tgt(bus.dnpc_i_ifu) : pc_q + XLEN'(4);

    if (squash_q && bus.resp_valid_i_ifu) begin
      squash_d = 1'b0;
    end

    if (bus.flush_i_ifu) begin
      pc_d     = flush_tgt;
      squash_d = in_flight && !bus.resp_valid_i_ifu;
      state_d  = S_REQ;
`ifdef IFU_MISALIGN_TRAP_EN
      if (|bus.flush_pc_i_ifu[1:0]) begin
        state_d = S_HALT;
      end
`endif
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.resp_valid_i_ifu) begin
            inst_d  = bus.resp_inst_i_ifu;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.inst_ready_i_ifu) begin
            pc_d    = redir_tgt;
            state_d = S_REQ;
`ifdef IFU_MISALIGN_TRAP_EN
            if (bus.jump_branch_i_ifu && (|bus.dnpc_i_ifu[1:0])) begin
              state_d = S_HALT;
            end
`endif
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    req_valid_d  = (state_d == S_REQ) && !squash_d;
    inst_valid_d = (state_d == S_HOLD);
`ifdef IFU_MISALIGN_TRAP_EN
    misalign_d   = (state_d == S_HALT);
`endif
  end

  assign bus.req_valid_o_ifu  = req_valid_q;
  assign bus.req_addr_o_ifu   = pc_q;
  assign bus.inst_valid_o_ifu = inst_valid_q;
  assign bus.inst_o_ifu       = inst_q;
  assign bus.pc_o_ifu         = pc_q;
`ifdef IFU_MISALIGN_TRAP_EN
  assign bus.misalign_o_ifu   = misalign_q;
`endif
endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu; inputs driven 1ns after the rising edge, outputs sampled there.
module tb_ifu;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ifu_if bus();

  ifu #(.RESET_PC(RST_PC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_ready_i_ifu   = 1'b0;
    bus.resp_valid_i_ifu  = 1'b0;
    bus.resp_inst_i_ifu   = '0;
    bus.inst_ready_i_ifu  = 1'b0;
    bus.jump_branch_i_ifu = 1'b0;
    bus.dnpc_i_ifu        = '0;
    bus.flush_i_ifu       = 1'b0;
    bus.flush_pc_i_ifu    = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    tick();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got=%b exp=0", bus.req_valid_o_ifu); end
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid got=%b exp=0", bus.inst_valid_o_ifu); end
    n_checks++; if (bus.pc_o_ifu !== RST_PC) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_o_ifu, RST_PC); end
    n_checks++; if (bus.inst_o_ifu !== 32'h0) begin n_fail++; $display("FAIL reset_inst got=%h exp=0", bus.inst_o_ifu); end
`ifdef IFU_MISALIGN_TRAP_EN
    n_checks++; if (bus.misalign_o_ifu !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign_o_ifu); end
`endif
    rst = 1'b1;
    tick();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL first_req_valid got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== RST_PC) begin n_fail++; $display("FAIL first_req_addr got=%h exp=%h", bus.req_addr_o_ifu, RST_PC); end
  endtask

  // Zero-wait memory: request, response next cycle, immediate retire
  task automatic test_sequential();
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    bus.req_ready_i_ifu = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_pc   = RST_PC + 64'(4 * i);
      exp_inst = 32'hA000_0000 + 32'(i);
      n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL seq_req_valid[%0d] got=%b exp=1", i, bus.req_valid_o_ifu); end
      n_checks++; if (bus.req_addr_o_ifu !== exp_pc) begin n_fail++; $display("FAIL seq_req_addr[%0d] got=%h exp=%h", i, bus.req_addr_o_ifu, exp_pc); end
      tick();
      n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req_low[%0d] got=%b exp=0", i, bus.req_valid_o_ifu); end
      bus.resp_valid_i_ifu = 1'b1;
      bus.resp_inst_i_ifu  = exp_inst;
      tick();
      bus.resp_valid_i_ifu = 1'b0;
      n_checks++; if (bus.inst_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL seq_inst_valid[%0d] got=%b exp=1", i, bus.inst_valid_o_ifu); end
      n_checks++; if (bus.inst_o_ifu !== exp_inst) begin n_fail++; $display("FAIL seq_inst[%0d] got=%h exp=%h", i, bus.inst_o_ifu, exp_inst); end
      n_checks++; if (bus.pc_o_ifu !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc_o_ifu, exp_pc); end
      bus.inst_ready_i_ifu = 1'b1;
      tick();
      bus.inst_ready_i_ifu = 1'b0;
      n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL seq_inst_drop[%0d] got=%b exp=0", i, bus.inst_valid_o_ifu); end
    end
    bus.req_ready_i_ifu = 1'b0;
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_000C) begin n_fail++; $display("FAIL seq_next_addr got=%h exp=8000000c", bus.req_addr_o_ifu); end
  endtask

  // Request back-pressure, then a long HOLD with jump asserted but no retire, then a taken jump
  task automatic test_stall_and_jump();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL stall_req_valid[%0d] got=%b exp=1", i, bus.req_valid_o_ifu); end
      n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_000C) begin n_fail++; $display("FAIL stall_req_addr[%0d] got=%h exp=8000000c", i, bus.req_addr_o_ifu); end
    end
    bus.req_ready_i_ifu = 1'b1;
    tick();
    bus.req_ready_i_ifu  = 1'b0;
    bus.resp_valid_i_ifu = 1'b1;
    bus.resp_inst_i_ifu  = 32'h0000_0013;
    tick();
    bus.resp_valid_i_ifu  = 1'b0;
    bus.jump_branch_i_ifu = 1'b1;
    bus.dnpc_i_ifu        = 64'h8000_0500;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (bus.inst_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got=%b exp=1", i, bus.inst_valid_o_ifu); end
      n_checks++; if (bus.inst_o_ifu !== 32'h0000_0013) begin n_fail++; $display("FAIL hold_inst[%0d] got=%h exp=00000013", i, bus.inst_o_ifu); end
      n_checks++; if (bus.pc_o_ifu !== 64'h8000_000C) begin n_fail++; $display("FAIL hold_pc[%0d] got=%h exp=8000000c", i, bus.pc_o_ifu); end
      n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL hold_no_req[%0d] got=%b exp=0", i, bus.req_valid_o_ifu); end
    end
    bus.inst_ready_i_ifu = 1'b1;
    bus.dnpc_i_ifu       = 64'h8000_0100;
    tick();
    idle_inputs();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL jump_req_valid got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0100) begin n_fail++; $display("FAIL jump_req_addr got=%h exp=80000100", bus.req_addr_o_ifu); end
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL jump_inst_drop got=%b exp=0", bus.inst_valid_o_ifu); end
  endtask

  // Flush in WAIT: stale response three cycles later must be swallowed
  task automatic test_flush_wait();
    bus.req_ready_i_ifu = 1'b1;
    tick();
    bus.req_ready_i_ifu = 1'b0;
    bus.flush_i_ifu     = 1'b1;
    bus.flush_pc_i_ifu  = 64'h8000_0200;
    tick();
    idle_inputs();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fw_squash_req got=%b exp=0", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0200) begin n_fail++; $display("FAIL fw_pc got=%h exp=80000200", bus.req_addr_o_ifu); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fw_squash_hold[%0d] got=%b exp=0", i, bus.req_valid_o_ifu); end
    end
    bus.resp_valid_i_ifu = 1'b1;
    bus.resp_inst_i_ifu  = 32'hDEAD_BEEF;
    tick();
    bus.resp_valid_i_ifu = 1'b0;
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL fw_resume_req got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0200) begin n_fail++; $display("FAIL fw_resume_addr got=%h exp=80000200", bus.req_addr_o_ifu); end
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fw_stale_valid got=%b exp=0", bus.inst_valid_o_ifu); end
    n_checks++; if (bus.inst_o_ifu !== 32'h0000_0013) begin n_fail++; $display("FAIL fw_stale_inst got=%h exp=00000013", bus.inst_o_ifu); end
    tick();
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fw_stale_late got=%b exp=0", bus.inst_valid_o_ifu); end
  endtask

  // Flush coincident with request acceptance, then flush coincident with the response
  task automatic test_flush_edges();
    bus.req_ready_i_ifu = 1'b1;
    bus.flush_i_ifu     = 1'b1;
    bus.flush_pc_i_ifu  = 64'h8000_0040;
    tick();
    idle_inputs();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fr_squash_req got=%b exp=0", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0040) begin n_fail++; $display("FAIL fr_pc got=%h exp=80000040", bus.req_addr_o_ifu); end
    bus.resp_valid_i_ifu = 1'b1;
    bus.resp_inst_i_ifu  = 32'hCAFE_BABE;
    tick();
    bus.resp_valid_i_ifu = 1'b0;
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL fr_resume_req got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fr_stale_valid got=%b exp=0", bus.inst_valid_o_ifu); end
    bus.req_ready_i_ifu = 1'b1;
    tick();
    bus.req_ready_i_ifu  = 1'b0;
    bus.flush_i_ifu      = 1'b1;
    bus.flush_pc_i_ifu   = 64'h8000_0080;
    bus.resp_valid_i_ifu = 1'b1;
    bus.resp_inst_i_ifu  = 32'h2222_2222;
    tick();
    idle_inputs();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL fc_no_squash got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0080) begin n_fail++; $display("FAIL fc_addr got=%h exp=80000080", bus.req_addr_o_ifu); end
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fc_valid got=%b exp=0", bus.inst_valid_o_ifu); end
    n_checks++; if (bus.inst_o_ifu !== 32'h0000_0013) begin n_fail++; $display("FAIL fc_inst got=%h exp=00000013", bus.inst_o_ifu); end
  endtask

  // Flush wins over a same-cycle retire with taken jump
  task automatic test_flush_vs_retire();
    bus.req_ready_i_ifu = 1'b1;
    tick();
    bus.req_ready_i_ifu  = 1'b0;
    bus.resp_valid_i_ifu = 1'b1;
    bus.resp_inst_i_ifu  = 32'h1111_1111;
    tick();
    bus.resp_valid_i_ifu = 1'b0;
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL fvr_present got=%b exp=1", bus.inst_valid_o_ifu); end
    n_checks++; if (bus.pc_o_ifu !== 64'h8000_0080) begin n_fail++; $display("FAIL fvr_pc got=%h exp=80000080", bus.pc_o_ifu); end
    bus.flush_i_ifu       = 1'b1;
    bus.flush_pc_i_ifu    = 64'h8000_0200;
    bus.inst_ready_i_ifu  = 1'b1;
    bus.jump_branch_i_ifu = 1'b1;
    bus.dnpc_i_ifu        = 64'h8000_0300;
    tick();
    idle_inputs();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL fvr_req got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0200) begin n_fail++; $display("FAIL fvr_addr got=%h exp=80000200", bus.req_addr_o_ifu); end
    n_checks++; if (bus.inst_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL fvr_drop got=%b exp=0", bus.inst_valid_o_ifu); end
  endtask

  task automatic test_reset_mid_wait();
    bus.req_ready_i_ifu = 1'b1;
    tick();
    bus.req_ready_i_ifu = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL rmw_req got=%b exp=0", bus.req_valid_o_ifu); end
    n_checks++; if (bus.pc_o_ifu !== RST_PC) begin n_fail++; $display("FAIL rmw_pc got=%h exp=%h", bus.pc_o_ifu, RST_PC); end
    n_checks++; if (bus.inst_o_ifu !== 32'h0) begin n_fail++; $display("FAIL rmw_inst got=%h exp=0", bus.inst_o_ifu); end
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL rmw_resume got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== RST_PC) begin n_fail++; $display("FAIL rmw_addr got=%h exp=%h", bus.req_addr_o_ifu, RST_PC); end
  endtask

  task automatic test_misalign();
    bus.req_ready_i_ifu = 1'b1;
    tick();
    bus.req_ready_i_ifu  = 1'b0;
    bus.resp_valid_i_ifu = 1'b1;
    bus.resp_inst_i_ifu  = 32'h0000_006F;
    tick();
    bus.resp_valid_i_ifu  = 1'b0;
    bus.inst_ready_i_ifu  = 1'b1;
    bus.jump_branch_i_ifu = 1'b1;
    bus.dnpc_i_ifu        = 64'h8000_0102;
    tick();
    idle_inputs();
`ifdef IFU_MISALIGN_TRAP_EN
    n_checks++; if (bus.pc_o_ifu !== 64'h8000_0102) begin n_fail++; $display("FAIL mis_pc got=%h exp=80000102", bus.pc_o_ifu); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.misalign_o_ifu !== 1'b1) begin n_fail++; $display("FAIL mis_flag[%0d] got=%b exp=1", i, bus.misalign_o_ifu); end
      n_checks++; if (bus.req_valid_o_ifu !== 1'b0) begin n_fail++; $display("FAIL mis_no_req[%0d] got=%b exp=0", i, bus.req_valid_o_ifu); end
      tick();
    end
    bus.flush_i_ifu    = 1'b1;
    bus.flush_pc_i_ifu = RST_PC;
    tick();
    idle_inputs();
    n_checks++; if (bus.misalign_o_ifu !== 1'b0) begin n_fail++; $display("FAIL mis_clear got=%b exp=0", bus.misalign_o_ifu); end
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL mis_resume got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== RST_PC) begin n_fail++; $display("FAIL mis_addr got=%h exp=%h", bus.req_addr_o_ifu, RST_PC); end
`else
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL mis_req got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0100) begin n_fail++; $display("FAIL mis_redir_addr got=%h exp=80000100", bus.req_addr_o_ifu); end
    bus.flush_i_ifu    = 1'b1;
    bus.flush_pc_i_ifu = 64'h8000_0206;
    tick();
    idle_inputs();
    n_checks++; if (bus.req_valid_o_ifu !== 1'b1) begin n_fail++; $display("FAIL mis_flush_req got=%b exp=1", bus.req_valid_o_ifu); end
    n_checks++; if (bus.req_addr_o_ifu !== 64'h8000_0204) begin n_fail++; $display("FAIL mis_flush_addr got=%h exp=80000204", bus.req_addr_o_ifu); end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sequential();
    test_stall_and_jump();
    test_flush_wait();
    test_flush_edges();
    test_flush_vs_retire();
    test_reset_mid_wait();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
